mem_wb_stage: RTL
=================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The ports SHALL be, one per line: name, direction, width, meaning.
- clock  in  1  single rising-edge clock
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the MEM/WB register contents
- flush  in  1  squash the incoming instruction
- in_valid  in  1  MEM stage holds a real instruction
- reg_write  in  1  instruction writes the register file
- mem_to_reg  in  1  1 = writeback load data, 0 = writeback ALU result
- load_type  in  3  load width/sign code (see REQ-010)
- dest_reg  in  5  destination register number
- alu_result  in  32  ALU result / memory address from EX/MEM
- mem_data  in  32  word read from the data memory block output
- wb_valid  out  1  registered instruction valid
- wb_reg_write  out  1  register-file write enable
- wb_dest  out  5  register-file write address
- wb_data  out  32  register-file write data
- retired_count  out  32  count of instructions retired

Function
REQ-003 The block SHALL update all wb_* outputs on the rising clock edge, one cycle after its inputs.
- There SHALL be no combinational path from any input to any output.
REQ-004 On an edge with reset=0, flush=1: wb_valid, wb_reg_write, wb_dest and wb_data SHALL be cleared to 0.
- flush SHALL take priority over stall.
REQ-005 On an edge with reset=0, flush=0, stall=1: all wb_* outputs and retired_count SHALL hold their values.
REQ-006 On an edge with reset=0, flush=0, stall=0, the block SHALL capture:
- wb_valid = in_valid
- wb_dest = dest_reg
- wb_reg_write = in_valid & reg_write & (dest_reg != 0)
REQ-007 Writes to register 0 SHALL never be signalled, even when in_valid=1 and reg_write=1.
REQ-008 In the capture case with mem_to_reg=0, wb_data SHALL equal alu_result.
REQ-009 In the capture case with mem_to_reg=1, wb_data SHALL be extracted from mem_data per load_type.
- The byte offset SHALL be alu_result[1:0], with little-endian lanes: lane 0 = mem_data[7:0].
REQ-010 The load_type codes SHALL be:
- 000 LW: full word
- 001 LB: lane byte, sign-extended
- 010 LBU: lane byte, zero-extended
- 011 LH: half selected by alu_result[1] (0 = bits 15:0), sign-extended
- 100 LHU: same half, zero-extended
- 101-111: reserved, treated as LW
REQ-011 For LH/LHU, alu_result[0] SHALL be ignored; no misalignment trap SHALL be raised.
REQ-012 When in_valid=0 in the capture case, wb_data SHALL still be computed, but wb_reg_write SHALL be 0.
REQ-013 retired_count SHALL increment by 1 on every capture edge with in_valid=1.
- It SHALL wrap from 0xFFFFFFFF to 0x00000000.
- It SHALL not change on stall or flush edges.
REQ-014 The block SHALL contain no other state: one register stage plus the counter.

Reset
REQ-015 On an edge with reset=1, wb_valid, wb_reg_write, wb_dest, wb_data and retired_count SHALL become 0.
- reset SHALL override stall and flush.
REQ-016 Reset asserted mid-stream SHALL discard the registered instruction with no register-file write on the following cycle.

Structure
REQ-017 The load_type code constants SHALL live in a shared pipeline package, used by both the decode logic and this block.
REQ-018 Load extraction SHALL be a combinational sub-module named load_extender.
- Inputs: mem_data, offset, load_type.
- Output: 32-bit extended word.
REQ-019 The counter and the MEM/WB register SHALL stay in mem_wb_stage.

Verification
REQ-020 LB sign: mem_data=0x8000_7F00, alu_result=0x0000_0003, load_type=001, mem_to_reg=1 -> next cycle wb_data=0xFFFF_FF80.
REQ-021 LBU/LHU lanes:
- mem_data=0x1234_ABCD, alu_result low bits=01, LBU -> wb_data=0x0000_00AB.
- Same mem_data, alu_result low bits=10, LHU -> wb_data=0x0000_1234.
REQ-022 Register 0 guard: in_valid=1, reg_write=1, dest_reg=0, alu_result=0x55 -> wb_reg_write=0, wb_valid=1, wb_data=0x55.
REQ-023 Stall/flush priority:
- Capture dest=7, then stall=1 for 3 cycles with new inputs -> outputs and retired_count unchanged.
- Then stall=1 with flush=1 -> wb_valid=0, wb_reg_write=0.
REQ-024 Counter wrap: retired_count preloaded to 0xFFFF_FFFF through 2^32-1 valid captures (or forced), one more valid capture -> 0x0000_0000.
REQ-025 Reset priority: reset=1 with stall=1 and flush=0 while wb_valid=1 -> all outputs 0 next cycle; first valid capture after reset -> retired_count=1.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared pipeline definitions: load width/sign codes used by decode and writeback.
package mem_wb_stage_pkg;

  localparam logic [2:0] LT_LW  = 3'b000;
  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LBU = 3'b010;
  localparam logic [2:0] LT_LH  = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_regs_t;

  localparam wb_regs_t WB_REGS_CLEAR = '{valid: 1'b0, reg_write: 1'b0, dest: 5'd0, data: 32'd0};

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: pipeline controls and MEM-side fields in, writeback fields out.
interface mem_wb_stage_if;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        reg_write;
  logic        mem_to_reg;
  logic [2:0]  load_type;
  logic [4:0]  dest_reg;
  logic [31:0] alu_result;
  logic [31:0] mem_data;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic [31:0] retired_count;

  modport master (
    output stall, flush, in_valid, reg_write, mem_to_reg, load_type, dest_reg,
           alu_result, mem_data,
    input  wb_valid, wb_reg_write, wb_dest, wb_data, retired_count
  );

  modport slave (
    input  stall, flush, in_valid, reg_write, mem_to_reg, load_type, dest_reg,
           alu_result, mem_data,
    output wb_valid, wb_reg_write, wb_dest, wb_data, retired_count
  );
endinterface

// File: rtl/mem_wb_stage_load_extender.sv
// Combinational load lane selection and sign/zero extension of the data-memory word.
module load_extender
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] ext_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte = mem_data[7:0];
    case (offset)
      2'd0: lane_byte = mem_data[7:0];
      2'd1: lane_byte = mem_data[15:8];
      2'd2: lane_byte = mem_data[23:16];
      2'd3: lane_byte = mem_data[31:24];
      default: lane_byte = mem_data[7:0];
    endcase
    // offset[0] is deliberately ignored for halfwords; misaligned LH/LHU just use the containing half
    lane_half = offset[1] ? mem_data[31:16] : mem_data[15:0];
  end

  always_comb begin
    ext_data = mem_data;
    case (load_type)
      LT_LB:   ext_data = {{24{lane_byte[7]}}, lane_byte};
      LT_LBU:  ext_data = {24'd0, lane_byte};
      LT_LH:   ext_data = {{16{lane_half[15]}}, lane_half};
      LT_LHU:  ext_data = {16'd0, lane_half};
      default: ext_data = mem_data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, register-0 write guard and retired-instruction counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  mem_wb_stage_if.slave    bus
);

  wb_regs_t    wb_q;
  logic [31:0] cnt_q;
  logic [31:0] load_word;
  logic [31:0] next_data;

  load_extender u_load_extender (
    .mem_data  (bus.mem_data),
    .offset    (bus.alu_result[1:0]),
    .load_type (bus.load_type),
    .ext_data  (load_word)
  );

  assign next_data = bus.mem_to_reg ? load_word : bus.alu_result;

  // reset beats flush, flush beats stall; the counter only moves on real captures
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_q  <= WB_REGS_CLEAR;
      cnt_q <= 32'd0;
    end else if (bus.flush) begin
      wb_q  <= WB_REGS_CLEAR;
    end else if (!bus.stall) begin
      wb_q.valid     <= bus.in_valid;
      wb_q.reg_write <= bus.in_valid & bus.reg_write & (bus.dest_reg != 5'd0);
      wb_q.dest      <= bus.dest_reg;
      wb_q.data      <= next_data;
      if (bus.in_valid) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  assign bus.wb_valid      = wb_q.valid;
  assign bus.wb_reg_write  = wb_q.reg_write;
  assign bus.wb_dest       = wb_q.dest;
  assign bus.wb_data       = wb_q.data;
  assign bus.retired_count = cnt_q;

endmodule
